// File: rtl/game_pkg.sv
// Shared game-flow constants: state encodings and track indices.
// Used by the controller, the pixel generator and the display driver.
package game_pkg;

    typedef enum logic [2:0] {
        STATE_RESET = 3'b000,
        STATE_GAME  = 3'b001,
        STATE_OVER  = 3'b010,
        STATE_PAUSE = 3'b011,
        STATE_DYING = 3'b100
    } state_t;

    localparam int TRK_TITLE = 0;
    localparam int TRK_GAME  = 1;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous input bit.
// The whole chain clears to 0 on reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/game_state_ctrl.sv
// Registered game-flow FSM: lives, timed respawn and the
// PMOD audio track mux with mute while paused.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int LIVES       = 3,
    parameter int LIVES_W     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int RESPAWN_CYC = 4,
    parameter int NUM_TRACKS  = 3,
    parameter int TRACK_W     = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sw_run,
    input  logic                          sw_over,
    input  logic                          sw_pause,
    input  logic                          die,
    input  logic [NUM_TRACKS*TRACK_W-1:0] track_bus,
    output logic [2:0]                    state,
    output logic [LIVES_W-1:0]            lives,
    output logic                          start_pulse,
    output logic [$clog2(NUM_TRACKS)-1:0] track_sel,
    output logic [TRACK_W-1:0]            pmod_out
);

    localparam int SEL_W = $clog2(NUM_TRACKS);
    localparam int CNT_W = $clog2(RESPAWN_CYC + 1);
    localparam logic [LIVES_W-1:0] LIVES_V  = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0] LIVES_1  = LIVES_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(RESPAWN_CYC - 1);
    localparam logic [CNT_W-1:0]   CNT_1    = CNT_W'(1);

    logic sw_run_s, sw_over_s, sw_pause_s, die_s;
    logic die_s_d1, die_rise;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_run (
        .clk(clk), .rst(rst), .d(sw_run), .q(sw_run_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_over (
        .clk(clk), .rst(rst), .d(sw_over), .q(sw_over_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_pause (
        .clk(clk), .rst(rst), .d(sw_pause), .q(sw_pause_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_die (
        .clk(clk), .rst(rst), .d(die), .q(die_s)
    );

    // Registered rising edge: a held-high die yields a single pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            die_s_d1 <= 1'b0;
            die_rise <= 1'b0;
        end else begin
            die_s_d1 <= die_s;
            die_rise <= die_s & ~die_s_d1;
        end
    end

    state_t               cur, nxt;
    logic [LIVES_W-1:0]   nxt_lives;
    logic [CNT_W-1:0]     cnt, nxt_cnt;
    logic [SEL_W-1:0]     nxt_trk;
    logic [TRACK_W-1:0]   nxt_slice;

    always_comb begin
        nxt       = cur;
        nxt_lives = lives;
        nxt_cnt   = cnt;
        if (!sw_run_s) begin
            nxt       = STATE_RESET;
            nxt_lives = LIVES_V;
        end else begin
            unique case (cur)
                STATE_RESET: begin
                    nxt       = STATE_GAME;
                    nxt_lives = LIVES_V;
                end
                STATE_GAME: begin
                    if (die_rise) begin
                        if (lives <= LIVES_1) begin
                            nxt       = STATE_OVER;
                            nxt_lives = '0;
                        end else begin
                            nxt       = STATE_DYING;
                            nxt_lives = lives - LIVES_1;
                            nxt_cnt   = CNT_LOAD;
                        end
                    end else if (sw_over_s) begin
                        nxt = STATE_OVER;
                    end else if (sw_pause_s) begin
                        nxt = STATE_PAUSE;
                    end
                end
                STATE_DYING: begin
                    if (cnt == '0) nxt = STATE_GAME;
                    else           nxt_cnt = cnt - CNT_1;
                end
                STATE_PAUSE: begin
                    if (sw_over_s)        nxt = STATE_OVER;
                    else if (!sw_pause_s) nxt = STATE_GAME;
                end
                STATE_OVER: begin
                    nxt = STATE_OVER;
                end
                default: begin
                    nxt = STATE_RESET;
                end
            endcase
        end
    end

    // Audio follows the next state so it switches on the same edge.
    always_comb begin
        if (nxt == STATE_RESET)     nxt_trk = SEL_W'(TRK_TITLE);
        else if (nxt == STATE_OVER) nxt_trk = SEL_W'(NUM_TRACKS - 1);
        else                        nxt_trk = SEL_W'(TRK_GAME);
        nxt_slice = track_bus[int'(nxt_trk)*TRACK_W +: TRACK_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= STATE_RESET;
            lives       <= LIVES_V;
            cnt         <= '0;
            start_pulse <= 1'b0;
            track_sel   <= '0;
            pmod_out    <= '0;
        end else begin
            cur         <= nxt;
            lives       <= nxt_lives;
            cnt         <= nxt_cnt;
            start_pulse <= (cur == STATE_RESET) && (nxt == STATE_GAME);
            track_sel   <= nxt_trk;
            pmod_out    <= (nxt == STATE_PAUSE) ? '0 : nxt_slice;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios plus random
// stimulus, checked every cycle against a behavioural model.
module tb_game_state_ctrl;

    localparam int LIVES = 3;
    localparam int LW    = 2;
    localparam int SYNC  = 2;
    localparam int RESP  = 4;
    localparam int NT    = 3;
    localparam int TW    = 3;
    localparam int BW    = NT * TW;

    localparam int S_RESET = 0;
    localparam int S_GAME  = 1;
    localparam int S_OVER  = 2;
    localparam int S_PAUSE = 3;
    localparam int S_DYING = 4;

    logic          clk = 1'b0;
    logic          rst, sw_run, sw_over, sw_pause, die;
    logic [BW-1:0] track_bus;
    logic [2:0]    state;
    logic [LW-1:0] lives;
    logic          start_pulse;
    logic [1:0]    track_sel;
    logic [TW-1:0] pmod_out;

    game_state_ctrl #(
        .LIVES(LIVES), .LIVES_W(LW), .SYNC_STAGES(SYNC),
        .RESPAWN_CYC(RESP), .NUM_TRACKS(NT), .TRACK_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .sw_run(sw_run), .sw_over(sw_over),
        .sw_pause(sw_pause), .die(die), .track_bus(track_bus),
        .state(state), .lives(lives), .start_pulse(start_pulse),
        .track_sel(track_sel), .pmod_out(pmod_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    bit freeze = 1'b0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: input history per sampling edge, plain game rules.
    int         m_st = S_RESET;
    int         m_lives = LIVES;
    int         m_left = 0;
    int         m_trk = 0;
    bit         m_start = 1'b0;
    logic [TW-1:0] m_pmod = '0;
    bit h_run[8], h_over[8], h_pause[8], h_die[8];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = S_RESET; m_lives = LIVES; m_left = 0;
            m_trk = 0; m_start = 1'b0; m_pmod = '0;
            for (int i = 0; i < 8; i++) begin
                h_run[i] = 0; h_over[i] = 0; h_pause[i] = 0; h_die[i] = 0;
            end
        end else begin : step
            int prev;
            bit run, ov, pa, rise;
            for (int i = 7; i > 0; i--) begin
                h_run[i] = h_run[i-1]; h_over[i] = h_over[i-1];
                h_pause[i] = h_pause[i-1]; h_die[i] = h_die[i-1];
            end
            h_run[0] = sw_run; h_over[0] = sw_over;
            h_pause[0] = sw_pause; h_die[0] = die;
            run  = h_run[SYNC];
            ov   = h_over[SYNC];
            pa   = h_pause[SYNC];
            rise = h_die[SYNC+1] & !h_die[SYNC+2];
            prev = m_st;
            if (!run) begin
                m_st = S_RESET; m_lives = LIVES;
            end else begin
                case (m_st)
                    S_RESET: begin m_st = S_GAME; m_lives = LIVES; end
                    S_GAME: begin
                        if (rise) begin
                            if (m_lives <= 1) begin
                                m_st = S_OVER; m_lives = 0;
                            end else begin
                                m_lives--; m_st = S_DYING; m_left = RESP;
                            end
                        end else if (ov) m_st = S_OVER;
                        else if (pa) m_st = S_PAUSE;
                    end
                    S_DYING: begin
                        m_left--;
                        if (m_left == 0) m_st = S_GAME;
                    end
                    S_PAUSE: begin
                        if (ov) m_st = S_OVER;
                        else if (!pa) m_st = S_GAME;
                    end
                    default: ;
                endcase
            end
            m_start = (prev == S_RESET) && (m_st == S_GAME);
            m_trk = (m_st == S_RESET) ? 0 : (m_st == S_OVER) ? NT - 1 : 1;
            m_pmod = (m_st == S_PAUSE) ? '0 : track_bus[m_trk*TW +: TW];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", state, m_st);
            chk("lives", lives, m_lives);
            chk("start_pulse", start_pulse, m_start);
            chk("track_sel", track_sel, m_trk);
            chk("pmod_out", pmod_out, m_pmod);
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            if (!freeze) track_bus = BW'($urandom);
        end
    endtask

    task automatic die_pulse();
        die = 1'b1;
        tick(2);
        die = 1'b0;
    endtask

    task automatic wait_state(int s, int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick(1);
            if (state == 3'(s)) hit = 1'b1;
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL wait_state: got %0d want %0d", state, s);
        end
    endtask

    initial begin
        int cnt;
        rst = 1'b1; sw_run = 1'b1; sw_over = 1'b0;
        sw_pause = 1'b0; die = 1'b0; track_bus = '0;
        tick(2);
        chk_en = 1'b1;
        chk("rst_state", state, 0);
        chk("rst_lives", lives, 3);
        chk("rst_pmod", pmod_out, 0);
        chk("rst_sel", track_sel, 0);
        rst = 1'b0;
        tick(2);
        chk("pre_start", state, 0);
        tick(1);
        chk("start_state", state, 1);
        chk("start_pulse_hi", start_pulse, 1);
        chk("start_sel", track_sel, 1);
        chk("start_lives", lives, 3);
        tick(1);
        chk("start_pulse_lo", start_pulse, 0);

        tick(5);
        die_pulse();
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (state == 3'd4) cnt++;
        end
        chk("dying_len", cnt, 4);
        chk("die1_lives", lives, 2);
        chk("die1_state", state, 1);
        die_pulse(); tick(12);
        chk("die2_lives", lives, 1);
        die_pulse(); tick(6);
        chk("die3_state", state, 2);
        chk("die3_lives", lives, 0);
        chk("die3_sel", track_sel, 2);
        repeat (4) begin die_pulse(); tick(2); end
        chk("over_sticky", state, 2);

        sw_run = 1'b0; tick(4);
        chk("restart_rst", state, 0);
        chk("restart_lives", lives, 3);
        sw_run = 1'b1; tick(2);
        chk("restart_wait", state, 0);
        tick(1);
        chk("restart_game", state, 1);
        chk("restart_pulse", start_pulse, 1);

        tick(3); die = 1'b1; tick(50); die = 1'b0; tick(10);
        chk("held_lives", lives, 2);
        chk("held_state", state, 1);
        die = 1'b1; tick(1); die = 1'b0; tick(1);
        die = 1'b1; tick(1); die = 1'b0; tick(12);
        chk("mask_lives", lives, 1);

        sw_run = 1'b0; tick(4); sw_run = 1'b1; tick(5);
        die_pulse(); tick(12);
        chk("prep_lives", lives, 2);

        freeze = 1'b1;
        track_bus = 9'b101_110_011;
        sw_pause = 1'b1; tick(4);
        chk("pause_state", state, 3);
        chk("pause_pmod", pmod_out, 0);
        die_pulse(); tick(1); die_pulse(); tick(8);
        chk("pause_lives", lives, 2);
        sw_pause = 1'b0; tick(3);
        chk("resume_state", state, 1);
        chk("resume_pmod", pmod_out, 3'b110);
        freeze = 1'b0;

        tick(2);
        die = 1'b1; tick(1);
        sw_over = 1'b1; sw_pause = 1'b1; tick(1);
        sw_over = 1'b0; tick(2);
        chk("prio_state", state, 4);
        chk("prio_lives", lives, 1);
        tick(8);
        chk("prio_pause", state, 3);
        die = 1'b0; sw_over = 1'b1; tick(4);
        chk("pause_over", state, 2);
        chk("pause_over_lives", lives, 1);
        chk("pause_over_sel", track_sel, 2);

        sw_over = 1'b0; sw_pause = 1'b0;
        sw_run = 1'b0; tick(4); sw_run = 1'b1; tick(5);
        die_pulse();
        wait_state(S_DYING, 10);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_lives", lives, 3);
        chk("mid_rst_pmod", pmod_out, 0);
        tick(2); rst = 1'b0; tick(6);

        for (int i = 0; i < 3000; i++) begin
            if (sw_run && $urandom_range(99) == 0) sw_run = 1'b0;
            else if (!sw_run && $urandom_range(3) == 0) sw_run = 1'b1;
            sw_over = ($urandom_range(99) == 0);
            if ($urandom_range(19) == 0) sw_pause = ~sw_pause;
            if ($urandom_range(3) == 0) die = ~die;
            tick(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
